// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signal bundle for mem_port_arbiter.
//   master : arbiter view (drives o_* responses, stalls and the memory issue channel)
//   slave  : environment view (drives requester inputs and memory responses)
// Signal groups:
//   IF requester  : i_if_req, i_if_addr, i_if_flush -> o_if_valid, o_if_rdata, o_if_err
//   DM requester  : i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_wstrb -> o_dm_valid, o_dm_rdata, o_dm_err
//   Hazard unit   : o_stall_if, o_stall_dm
//   Memory port   : o_mem_req/we/addr/wdata/wstrb, i_mem_ready, i_mem_rvalid, i_mem_rdata
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned STRB_W = DATA_W / 8;

    // Instruction-fetch requester
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              i_if_flush;
    logic              o_if_valid;
    logic [DATA_W-1:0] o_if_rdata;
    logic              o_if_err;

    // Data-memory requester
    logic              i_dm_req;
    logic              i_dm_we;
    logic [ADDR_W-1:0] i_dm_addr;
    logic [DATA_W-1:0] i_dm_wdata;
    logic [STRB_W-1:0] i_dm_wstrb;
    logic              o_dm_valid;
    logic [DATA_W-1:0] o_dm_rdata;
    logic              o_dm_err;

    // Hazard-unit stalls
    logic              o_stall_if;
    logic              o_stall_dm;

    // Shared memory port
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [STRB_W-1:0] o_mem_wstrb;
    logic              i_mem_ready;
    logic              i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    modport master (
        input  i_if_req, i_if_addr, i_if_flush,
        output o_if_valid, o_if_rdata, o_if_err,
        input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_wstrb,
        output o_dm_valid, o_dm_rdata, o_dm_err,
        output o_stall_if, o_stall_dm,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata
    );

    modport slave (
        output i_if_req, i_if_addr, i_if_flush,
        input  o_if_valid, o_if_rdata, o_if_err,
        output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_wstrb,
        input  o_dm_valid, o_dm_rdata, o_dm_err,
        input  o_stall_if, o_stall_dm,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one request/ready + rvalid memory port between instruction fetch (IF)
// and the data-memory stage (DM). One transaction outstanding at a time; DM has
// priority unless IF has been passed over STARVE_LIMIT times in a row.
// Ports:
//   i_clk, i_rst (async, active high), i_clk_en (global pipeline enable)
//   bus : mem_port_arbiter_if.master -- requester inputs/responses, stalls,
//         and the shared memory issue/response channel.
// TIMEOUT_CYCLES must be >= 2 so a minimum-latency access always completes.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clk_en,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ST_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e            state_q,     state_d;
    owner_e            owner_q,     owner_d;
    logic              discard_q,   discard_d;
    logic [ST_W-1:0]   starve_q,    starve_d;
    logic [TO_W-1:0]   tmo_q,       tmo_d;

    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

    logic              if_valid_q,  if_valid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              if_err_q,    if_err_d;
    logic              dm_valid_q,  dm_valid_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              dm_err_q,    dm_err_d;

    logic grant_if;
    logic grant_dm;
    logic tmo_hit;
    logic done;
    logic done_err;

    // State and registered outputs; everything holds while the pipeline is disabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            discard_q   <= 1'b0;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_err_q    <= 1'b0;
        end else if (i_clk_en) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            discard_q   <= discard_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            dm_valid_q  <= dm_valid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_err_q    <= dm_err_d;
        end
    end

    // Arbitration, transaction sequencing, timeout and response generation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        discard_d   = discard_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = 1'b0;
        dm_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_err_d    = 1'b0;
        done        = 1'b0;
        done_err    = 1'b0;

        // DM wins ties until IF has been passed over STARVE_LIMIT times.
        grant_if = bus.i_if_req && (!bus.i_dm_req || (starve_q == ST_W'(STARVE_LIMIT)));
        grant_dm = bus.i_dm_req && !grant_if;
        tmo_hit  = (tmo_q == TO_W'(TIMEOUT_CYCLES - 1));

        unique case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                if (grant_if) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_IF;
                    tmo_d       = '0;
                    starve_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end else if (grant_dm) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_DM;
                    tmo_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.i_dm_we;
                    mem_addr_d  = bus.i_dm_addr;
                    mem_wdata_d = bus.i_dm_wdata;
                    mem_wstrb_d = bus.i_dm_wstrb;
                    if (bus.i_if_req && (starve_q != ST_W'(STARVE_LIMIT))) begin
                        starve_d = starve_q + ST_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                tmo_d = tmo_q + TO_W'(1);
                // Abort wins over a last-cycle accept so the counter never runs past the limit.
                if (tmo_hit) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (bus.i_mem_ready) begin
                    state_d   = ST_WAIT;
                    mem_req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + TO_W'(1);
                if (bus.i_mem_rvalid) begin
                    done = 1'b1;
                end else if (tmo_hit) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // A redirect while a fetch is in flight drops its response but not the bus access.
        if ((state_q != ST_IDLE) && (owner_q == OWN_IF) && bus.i_if_flush) begin
            discard_d = 1'b1;
        end

        if (done) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            discard_d = 1'b0;
            if (owner_q == OWN_IF) begin
                if (!(discard_q || bus.i_if_flush)) begin
                    if_valid_d = 1'b1;
                    if_err_d   = done_err;
                    if_rdata_d = done_err ? '0 : bus.i_mem_rdata;
                end
            end else begin
                dm_valid_d = 1'b1;
                dm_err_d   = done_err;
                dm_rdata_d = (done_err || mem_we_q) ? '0 : bus.i_mem_rdata;
            end
        end
    end

    assign bus.o_if_valid  = if_valid_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_if_err    = if_err_q;
    assign bus.o_dm_valid  = dm_valid_q;
    assign bus.o_dm_rdata  = dm_rdata_q;
    assign bus.o_dm_err    = dm_err_q;
    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_wstrb = mem_wstrb_q;

    // Stalls follow the live request so the hazard unit reacts in the same cycle.
    assign bus.o_stall_if  = bus.i_if_req && !if_valid_q;
    assign bus.o_stall_dm  = bus.i_dm_req && !dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT_CYCLES = 8).
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    logic clk_en;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Starts in ISSUE: checks the issue, accepts it, waits gap cycles, returns rd.
    task automatic serve(input string tag, input logic [63:0] addr, input int gap,
                         input logic [63:0] rd);
        chk({tag, "_req"}, 64'(bus.o_mem_req), 64'd1);
        chk({tag, "_addr"}, bus.o_mem_addr, addr);
        bus.i_mem_ready = 1'b1;
        tick();
        bus.i_mem_ready = 1'b0;
        chk({tag, "_req_drop"}, 64'(bus.o_mem_req), 64'd0);
        repeat (gap) tick();
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rd;
        tick();
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
    endtask

    // The two response pulses must never coincide.
    always @(negedge clk) begin
        if (!rst) chk("excl", 64'(bus.o_if_valid & bus.o_dm_valid), 64'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1; clk_en = 1'b1;
        bus.i_if_req = 0; bus.i_if_addr = '0; bus.i_if_flush = 0;
        bus.i_dm_req = 0; bus.i_dm_we = 0; bus.i_dm_addr = '0;
        bus.i_dm_wdata = '0; bus.i_dm_wstrb = '0;
        bus.i_mem_ready = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
        tick(); tick();
        chk("rst_if_valid", 64'(bus.o_if_valid), 64'd0);
        chk("rst_dm_valid", 64'(bus.o_dm_valid), 64'd0);
        chk("rst_mem_req", 64'(bus.o_mem_req), 64'd0);
        chk("rst_mem_addr", bus.o_mem_addr, 64'd0);
        chk("rst_dm_err", 64'(bus.o_dm_err), 64'd0);
        rst = 1'b0;

        // IF-only fetch, one idle WAIT cycle before rvalid
        bus.i_if_req = 1; bus.i_if_addr = 64'h1000;
        #1 chk("t1_stall_pre", 64'(bus.o_stall_if), 64'd1);
        tick();
        chk("t1_we", 64'(bus.o_mem_we), 64'd0);
        serve("t1", 64'h1000, 1, 64'h00000013_00000093);
        chk("t1_valid", 64'(bus.o_if_valid), 64'd1);
        chk("t1_rdata", bus.o_if_rdata, 64'h00000013_00000093);
        chk("t1_err", 64'(bus.o_if_err), 64'd0);
        chk("t1_stall_done", 64'(bus.o_stall_if), 64'd0);
        bus.i_if_req = 0;
        tick();
        chk("t1_pulse_once", 64'(bus.o_if_valid), 64'd0);
        chk("t1_idle", 64'(bus.o_mem_req), 64'd0);

        // Simultaneous requests: DM first, then IF
        bus.i_dm_req = 1; bus.i_dm_we = 0; bus.i_dm_addr = 64'h2000;
        bus.i_if_req = 1; bus.i_if_addr = 64'h1008;
        tick();
        serve("t2dm", 64'h2000, 0, 64'hAAAA_0001);
        chk("t2_dm_valid", 64'(bus.o_dm_valid), 64'd1);
        chk("t2_dm_rdata", bus.o_dm_rdata, 64'hAAAA_0001);
        chk("t2_if_not_yet", 64'(bus.o_if_valid), 64'd0);
        chk("t2_stall_if", 64'(bus.o_stall_if), 64'd1);
        bus.i_dm_req = 0;
        tick();
        serve("t2if", 64'h1008, 0, 64'hBBBB_0002);
        chk("t2_if_valid", 64'(bus.o_if_valid), 64'd1);
        chk("t2_if_rdata", bus.o_if_rdata, 64'hBBBB_0002);
        bus.i_if_req = 0;
        tick();

        // Starvation: IF held across back-to-back DM requests
        bus.i_if_req = 1; bus.i_if_addr = 64'h1010;
        bus.i_dm_req = 1; bus.i_dm_addr = 64'h3000;
        for (int i = 0; i < 4; i++) begin
            tick();
            serve("t3dm", 64'h3000 + 64'(8 * i), 0, 64'h100 + 64'(i));
            chk("t3_dm_valid", 64'(bus.o_dm_valid), 64'd1);
            chk("t3_dm_rdata", bus.o_dm_rdata, 64'h100 + 64'(i));
            bus.i_dm_addr = 64'h3000 + 64'(8 * (i + 1));
        end
        tick();
        serve("t3if", 64'h1010, 0, 64'hC0DE);
        chk("t3_if_valid", 64'(bus.o_if_valid), 64'd1);
        chk("t3_if_rdata", bus.o_if_rdata, 64'hC0DE);
        bus.i_if_req = 0;
        tick();
        serve("t3dm5", 64'h3020, 0, 64'h105);
        chk("t3_dm5_valid", 64'(bus.o_dm_valid), 64'd1);
        bus.i_dm_req = 0;
        tick();

        // Store with requester inputs changing during a stalled ISSUE
        bus.i_dm_req = 1; bus.i_dm_we = 1; bus.i_dm_addr = 64'h4000;
        bus.i_dm_wdata = 64'hDEADBEEF; bus.i_dm_wstrb = 8'h0F;
        tick();
        bus.i_dm_we = 0; bus.i_dm_addr = 64'h5000;
        bus.i_dm_wdata = 64'h12345678; bus.i_dm_wstrb = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            chk("t4_req", 64'(bus.o_mem_req), 64'd1);
            chk("t4_we", 64'(bus.o_mem_we), 64'd1);
            chk("t4_addr", bus.o_mem_addr, 64'h4000);
            chk("t4_wdata", bus.o_mem_wdata, 64'hDEADBEEF);
            chk("t4_wstrb", 64'(bus.o_mem_wstrb), 64'h0F);
            chk("t4_stall_dm", 64'(bus.o_stall_dm), 64'd1);
            tick();
        end
        serve("t4", 64'h4000, 0, 64'hFFFF_FFFF);
        chk("t4_valid", 64'(bus.o_dm_valid), 64'd1);
        chk("t4_rdata_zero", bus.o_dm_rdata, 64'd0);
        chk("t4_err", 64'(bus.o_dm_err), 64'd0);
        chk("t4_stall_done", 64'(bus.o_stall_dm), 64'd0);
        bus.i_dm_req = 0; bus.i_dm_we = 0;
        tick();

        // Flush during WAIT of a fetch, then a redirected fetch
        bus.i_if_req = 1; bus.i_if_addr = 64'h1100;
        tick();
        bus.i_mem_ready = 1;
        tick();
        bus.i_mem_ready = 0;
        bus.i_if_flush = 1; bus.i_if_addr = 64'h2200;
        tick();
        bus.i_if_flush = 0;
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 64'hBAD;
        tick();
        bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
        chk("t5_suppressed", 64'(bus.o_if_valid), 64'd0);
        chk("t5_stall", 64'(bus.o_stall_if), 64'd1);
        chk("t5_req_idle", 64'(bus.o_mem_req), 64'd0);
        tick();
        chk("t5_still_none", 64'(bus.o_if_valid), 64'd0);
        serve("t5", 64'h2200, 0, 64'h600D);
        chk("t5_valid", 64'(bus.o_if_valid), 64'd1);
        chk("t5_rdata", bus.o_if_rdata, 64'h600D);
        bus.i_if_req = 0;
        tick();

        // Timeout with ready held low: abort after 8 ISSUE cycles
        bus.i_dm_req = 1; bus.i_dm_we = 0; bus.i_dm_addr = 64'h6000;
        tick();
        repeat (7) tick();
        chk("t6_req_held", 64'(bus.o_mem_req), 64'd1);
        chk("t6_no_valid", 64'(bus.o_dm_valid), 64'd0);
        tick();
        chk("t6_valid", 64'(bus.o_dm_valid), 64'd1);
        chk("t6_err", 64'(bus.o_dm_err), 64'd1);
        chk("t6_rdata", bus.o_dm_rdata, 64'd0);
        chk("t6_req_drop", 64'(bus.o_mem_req), 64'd0);
        bus.i_dm_req = 0;
        tick();
        chk("t6_err_clear", 64'(bus.o_dm_err), 64'd0);
        chk("t6_valid_clear", 64'(bus.o_dm_valid), 64'd0);

        // Clock enable low for 4 cycles in WAIT; rvalid during that time is ignored
        bus.i_dm_req = 1; bus.i_dm_addr = 64'h7000;
        tick();
        bus.i_mem_ready = 1;
        tick();
        bus.i_mem_ready = 0;
        clk_en = 0;
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 64'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t7_frozen_valid", 64'(bus.o_dm_valid), 64'd0);
            chk("t7_frozen_req", 64'(bus.o_mem_req), 64'd0);
        end
        clk_en = 1;
        bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
        tick();
        chk("t7_still_wait", 64'(bus.o_dm_valid), 64'd0);
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 64'h77;
        tick();
        bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
        chk("t7_valid", 64'(bus.o_dm_valid), 64'd1);
        chk("t7_rdata", bus.o_dm_rdata, 64'h77);
        bus.i_dm_req = 0;
        tick();

        // Asynchronous reset during ISSUE, then a stray rvalid
        bus.i_if_req = 1; bus.i_if_addr = 64'h8000;
        tick();
        chk("t8_issue", 64'(bus.o_mem_req), 64'd1);
        #2 rst = 1;
        #1;
        chk("t8_rst_req", 64'(bus.o_mem_req), 64'd0);
        chk("t8_rst_addr", bus.o_mem_addr, 64'd0);
        chk("t8_rst_dm_rdata", bus.o_dm_rdata, 64'd0);
        bus.i_if_req = 0;
        tick();
        rst = 0;
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 64'h99;
        tick();
        bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
        tick();
        chk("t8_stray_if", 64'(bus.o_if_valid), 64'd0);
        chk("t8_stray_dm", 64'(bus.o_dm_valid), 64'd0);
        chk("t8_idle_req", 64'(bus.o_mem_req), 64'd0);
        bus.i_dm_req = 1; bus.i_dm_addr = 64'h9000;
        tick();
        serve("t8", 64'h9000, 0, 64'h1234);
        chk("t8_valid", 64'(bus.o_dm_valid), 64'd1);
        chk("t8_rdata", bus.o_dm_rdata, 64'h1234);
        bus.i_dm_req = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
